// File: rtl/array_arbiter_if.sv
// Bundled signals of the two-client array arbiter: two client buses,
// the merged array bus and the per-client write counters.
interface array_arbiter_if #(
  parameter int AN = 8,
  parameter int DN = 8
);
  // client 0
  logic          c0_valid;
  logic          c0_we;
  logic [AN-1:0] c0_addr;
  logic [DN-1:0] c0_di;
  logic          c0_ready;
  logic [DN-1:0] c0_do;
  logic          c0_do_valid;
  // client 1
  logic          c1_valid;
  logic          c1_we;
  logic [AN-1:0] c1_addr;
  logic [DN-1:0] c1_di;
  logic          c1_ready;
  logic [DN-1:0] c1_do;
  logic          c1_do_valid;
  // merged array port
  logic          m_valid;
  logic          m_we;
  logic [AN-1:0] m_addr;
  logic [DN-1:0] m_di;
  logic          m_ready;
  logic [DN-1:0] m_do;
  // accepted-write counters
  logic [15:0]   c0_wr_cnt;
  logic [15:0]   c1_wr_cnt;

  // arbiter side
  modport slave (
    input  c0_valid, c0_we, c0_addr, c0_di,
    input  c1_valid, c1_we, c1_addr, c1_di,
    input  m_ready, m_do,
    output c0_ready, c0_do, c0_do_valid,
    output c1_ready, c1_do, c1_do_valid,
    output m_valid, m_we, m_addr, m_di,
    output c0_wr_cnt, c1_wr_cnt
  );

  // clients + array side
  modport master (
    output c0_valid, c0_we, c0_addr, c0_di,
    output c1_valid, c1_we, c1_addr, c1_di,
    output m_ready, m_do,
    input  c0_ready, c0_do, c0_do_valid,
    input  c1_ready, c1_do, c1_do_valid,
    input  m_valid, m_we, m_addr, m_di,
    input  c0_wr_cnt, c1_wr_cnt
  );
endinterface

// File: rtl/array_arbiter.sv
// Two-client array arbiter: round-robin grant with stall lock, combinational
// request path, one-cycle read-return routing and per-client write counters.

// Per-client return path: read-data hold register and accepted-write counter.
module array_arbiter_client #(
  parameter int DN = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_ret_i,   // array data in this cycle belongs to us
  input  logic          wr_acc_i,   // one of our writes is accepted this cycle
  input  logic [DN-1:0] m_do_i,
  output logic [DN-1:0] do_o,
  output logic          do_valid_o,
  output logic [15:0]   wr_cnt_o
);
  logic [DN-1:0] do_q, do_d;
  logic [15:0]   cnt_q, cnt_d;

  // Returned data is passed through in its cycle and held afterwards.
  always_comb begin
    do_d  = rd_ret_i ? m_do_i : do_q;
    cnt_d = wr_acc_i ? cnt_q + 16'd1 : cnt_q;
  end

  // Hold register and counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      do_q  <= '0;
      cnt_q <= '0;
    end else begin
      do_q  <= do_d;
      cnt_q <= cnt_d;
    end
  end

  assign do_o       = do_d;
  assign do_valid_o = rd_ret_i;
  assign wr_cnt_o   = cnt_q;
endmodule

module array_arbiter #(
  parameter int AN = 8,
  parameter int DN = 8
) (
  input  logic           clk,
  input  logic           rst,
  array_arbiter_if.slave bus
);
  localparam int NC = 2;

  typedef struct packed {
    logic          valid;
    logic          we;
    logic [AN-1:0] addr;
    logic [DN-1:0] di;
  } req_t;

  req_t [NC-1:0]          req;
  req_t                   gr;
  logic                   gnt;
  logic                   lock_hold;
  logic                   fire;
  logic                   m_vld;
  logic                   last_q, last_d;
  logic                   locked_q, locked_d;
  logic                   lock_who_q, lock_who_d;
  logic                   rd_pend_q, rd_pend_d;
  logic                   rd_who_q, rd_who_d;
  logic [NC-1:0]          cl_ready;
  logic [NC-1:0][DN-1:0]  cl_do;
  logic [NC-1:0]          cl_do_vld;
  logic [NC-1:0][15:0]    cl_cnt;

  assign req[0] = {bus.c0_valid, bus.c0_we, bus.c0_addr, bus.c0_di};
  assign req[1] = {bus.c1_valid, bus.c1_we, bus.c1_addr, bus.c1_di};

  // Grant: a stalled client keeps the port while it still asks for it;
  // otherwise single requester wins, contention alternates against last.
  always_comb begin
    gnt       = 1'b0;
    lock_hold = locked_q & req[lock_who_q].valid;
    if (lock_hold)                        gnt = lock_who_q;
    else if (req[0].valid & req[1].valid) gnt = ~last_q;
    else if (req[1].valid)                gnt = 1'b1;
    gr = req[gnt];
  end

  // Merged request is muted during reset so nothing transfers then.
  assign m_vld       = (req[0].valid | req[1].valid) & ~rst;
  assign fire        = m_vld & bus.m_ready;
  assign bus.m_valid = m_vld;
  assign bus.m_we    = gr.we;
  assign bus.m_addr  = gr.addr;
  assign bus.m_di    = gr.di;

  // Arbitration and read-return bookkeeping for the next cycle.
  always_comb begin
    last_d     = fire ? gnt : last_q;
    locked_d   = 1'b0;
    lock_who_d = lock_who_q;
    if (m_vld & ~bus.m_ready) begin
      locked_d   = 1'b1;
      lock_who_d = gnt;
    end
    rd_pend_d = fire & ~gr.we;
    rd_who_d  = fire ? gnt : rd_who_q;
  end

  // Arbiter state; last resets to 1 so client 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 1'b1;
      locked_q   <= 1'b0;
      lock_who_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_who_q   <= 1'b0;
    end else begin
      last_q     <= last_d;
      locked_q   <= locked_d;
      lock_who_q <= lock_who_d;
      rd_pend_q  <= rd_pend_d;
      rd_who_q   <= rd_who_d;
    end
  end

  // Per-client ready, return routing and counters.
  for (genvar i = 0; i < NC; i++) begin : g_cl
    assign cl_ready[i] = ~rst & (gnt == 1'(i)) & bus.m_ready;

    array_arbiter_client #(.DN(DN)) u_cl (
      .clk        (clk),
      .rst        (rst),
      .rd_ret_i   (rd_pend_q & (rd_who_q == 1'(i)) & ~rst),
      .wr_acc_i   (fire & gr.we & (gnt == 1'(i))),
      .m_do_i     (bus.m_do),
      .do_o       (cl_do[i]),
      .do_valid_o (cl_do_vld[i]),
      .wr_cnt_o   (cl_cnt[i])
    );
  end

  assign bus.c0_ready    = cl_ready[0];
  assign bus.c1_ready    = cl_ready[1];
  assign bus.c0_do       = cl_do[0];
  assign bus.c1_do       = cl_do[1];
  assign bus.c0_do_valid = cl_do_vld[0];
  assign bus.c1_do_valid = cl_do_vld[1];
  assign bus.c0_wr_cnt   = cl_cnt[0];
  assign bus.c1_wr_cnt   = cl_cnt[1];
endmodule

// File: tb/tb_array_arbiter.sv
// Directed bench for array_arbiter; inputs change on negedge, outputs are
// sampled 1 time unit later.
module tb_array_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  array_arbiter_if #(.AN(8), .DN(8)) bus ();

  array_arbiter #(.AN(8), .DN(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic idle;
    bus.c0_valid = 0; bus.c0_we = 0; bus.c0_addr = 0; bus.c0_di = 0;
    bus.c1_valid = 0; bus.c1_we = 0; bus.c1_addr = 0; bus.c1_di = 0;
    bus.m_ready  = 0; bus.m_do = 0;
  endtask

  task automatic drv_c0(input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.c0_valid = 1; bus.c0_we = we; bus.c0_addr = a; bus.c0_di = d;
  endtask

  task automatic drv_c1(input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.c1_valid = 1; bus.c1_we = we; bus.c1_addr = a; bus.c1_di = d;
  endtask

  task automatic test_reset;
    idle();
    rst = 1;
    drv_c0(1, 8'd1, 8'd1); drv_c1(0, 8'd2, 8'd2); bus.m_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    nvec++; if (bus.m_valid !== 1'b0) begin nerr++; $display("FAIL rst_m_valid got %b want 0", bus.m_valid); end
    nvec++; if ({bus.c0_ready, bus.c1_ready} !== 2'b00) begin nerr++; $display("FAIL rst_ready got %b want 00", {bus.c0_ready, bus.c1_ready}); end
    nvec++; if ({bus.c0_do_valid, bus.c1_do_valid} !== 2'b00) begin nerr++; $display("FAIL rst_do_valid got %b want 00", {bus.c0_do_valid, bus.c1_do_valid}); end
    nvec++; if ({bus.c0_wr_cnt, bus.c1_wr_cnt} !== 32'd0) begin nerr++; $display("FAIL rst_cnt got %h want 0", {bus.c0_wr_cnt, bus.c1_wr_cnt}); end
    nvec++; if ({bus.c0_do, bus.c1_do} !== 16'd0) begin nerr++; $display("FAIL rst_do got %h want 0", {bus.c0_do, bus.c1_do}); end
    @(negedge clk);
    rst = 0; idle();
  endtask

  task automatic test_contention;
    logic e0;
    drv_c0(1, 8'd1, 8'd10); drv_c1(1, 8'd2, 8'd20); bus.m_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      e0 = (i % 2 == 0);
      nvec++; if (bus.m_addr !== (e0 ? 8'd1 : 8'd2)) begin nerr++; $display("FAIL cont_addr%0d got %0d want %0d", i, bus.m_addr, e0 ? 1 : 2); end
      nvec++; if (bus.m_di !== (e0 ? 8'd10 : 8'd20)) begin nerr++; $display("FAIL cont_di%0d got %0d want %0d", i, bus.m_di, e0 ? 10 : 20); end
      nvec++; if ({bus.c0_ready, bus.c1_ready} !== {e0, ~e0}) begin nerr++; $display("FAIL cont_ready%0d got %b want %b", i, {bus.c0_ready, bus.c1_ready}, {e0, ~e0}); end
      nvec++; if (bus.m_valid !== 1'b1 || bus.m_we !== 1'b1) begin nerr++; $display("FAIL cont_mvw%0d got %b%b want 11", i, bus.m_valid, bus.m_we); end
      @(negedge clk);
    end
    idle(); #1;
    nvec++; if (bus.c0_wr_cnt !== 16'd3) begin nerr++; $display("FAIL cont_c0cnt got %0d want 3", bus.c0_wr_cnt); end
    nvec++; if (bus.c1_wr_cnt !== 16'd3) begin nerr++; $display("FAIL cont_c1cnt got %0d want 3", bus.c1_wr_cnt); end
  endtask

  task automatic test_stall_lock;
    // one c0 write so round-robin alone would now favour c1
    @(negedge clk); drv_c0(1, 8'd0, 8'd0); bus.m_ready = 1;
    @(negedge clk); idle();
    drv_c0(1, 8'd3, 8'd30); bus.m_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++; if (bus.m_addr !== 8'd3 || bus.m_valid !== 1'b1) begin nerr++; $display("FAIL lock_addr%0d got %0d/%b want 3/1", i, bus.m_addr, bus.m_valid); end
      nvec++; if ({bus.c0_ready, bus.c1_ready} !== 2'b00) begin nerr++; $display("FAIL lock_ready%0d got %b want 00", i, {bus.c0_ready, bus.c1_ready}); end
      @(negedge clk);
      if (i == 0) drv_c1(1, 8'd2, 8'd20);
    end
    bus.m_ready = 1; #1;
    nvec++; if (bus.m_addr !== 8'd3 || bus.m_di !== 8'd30) begin nerr++; $display("FAIL lock_xfer got %0d/%0d want 3/30", bus.m_addr, bus.m_di); end
    nvec++; if ({bus.c0_ready, bus.c1_ready} !== 2'b10) begin nerr++; $display("FAIL lock_xfer_rdy got %b want 10", {bus.c0_ready, bus.c1_ready}); end
    @(negedge clk); bus.c0_valid = 0; #1;
    nvec++; if (bus.m_addr !== 8'd2 || bus.c1_ready !== 1'b1) begin nerr++; $display("FAIL lock_next got %0d/%b want 2/1", bus.m_addr, bus.c1_ready); end
    @(negedge clk); idle(); #1;
    nvec++; if (bus.c0_wr_cnt !== 16'd5 || bus.c1_wr_cnt !== 16'd4) begin nerr++; $display("FAIL lock_cnt got %0d/%0d want 5/4", bus.c0_wr_cnt, bus.c1_wr_cnt); end
  endtask

  task automatic test_read_routing;
    drv_c1(0, 8'd2, 8'd0); bus.m_ready = 1; #1;
    nvec++; if (bus.c1_ready !== 1'b1 || bus.m_we !== 1'b0) begin nerr++; $display("FAIL rd_accept got %b/%b want 1/0", bus.c1_ready, bus.m_we); end
    @(negedge clk); idle(); bus.m_do = 8'd20; #1;
    nvec++; if (bus.c1_do_valid !== 1'b1 || bus.c1_do !== 8'd20) begin nerr++; $display("FAIL rd_ret got %b/%0d want 1/20", bus.c1_do_valid, bus.c1_do); end
    nvec++; if (bus.c0_do_valid !== 1'b0) begin nerr++; $display("FAIL rd_other got %b want 0", bus.c0_do_valid); end
    @(negedge clk); bus.m_do = 8'd99; #1;
    nvec++; if (bus.c1_do_valid !== 1'b0 || bus.c1_do !== 8'd20) begin nerr++; $display("FAIL rd_hold got %b/%0d want 0/20", bus.c1_do_valid, bus.c1_do); end
    nvec++; if (bus.c1_wr_cnt !== 16'd4) begin nerr++; $display("FAIL rd_nocnt got %0d want 4", bus.c1_wr_cnt); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); idle(); bus.m_ready = 1; drv_c0(0, 8'd5, 8'd0);
    @(negedge clk); bus.c0_valid = 0; drv_c1(0, 8'd6, 8'd0); bus.m_do = 8'd5; #1;
    nvec++; if (bus.c0_do_valid !== 1'b1 || bus.c0_do !== 8'd5 || bus.c1_do_valid !== 1'b0) begin nerr++; $display("FAIL b2b_r0 got %b/%0d/%b want 1/5/0", bus.c0_do_valid, bus.c0_do, bus.c1_do_valid); end
    nvec++; if (bus.c1_ready !== 1'b1) begin nerr++; $display("FAIL b2b_acc1 got %b want 1", bus.c1_ready); end
    @(negedge clk); bus.c1_valid = 0; drv_c0(0, 8'd7, 8'd0); bus.m_do = 8'd6; #1;
    nvec++; if (bus.c1_do_valid !== 1'b1 || bus.c1_do !== 8'd6 || bus.c0_do_valid !== 1'b0) begin nerr++; $display("FAIL b2b_r1 got %b/%0d/%b want 1/6/0", bus.c1_do_valid, bus.c1_do, bus.c0_do_valid); end
    @(negedge clk); idle(); bus.m_do = 8'd7; #1;
    nvec++; if (bus.c0_do_valid !== 1'b1 || bus.c0_do !== 8'd7 || bus.c1_do_valid !== 1'b0) begin nerr++; $display("FAIL b2b_r2 got %b/%0d/%b want 1/7/0", bus.c0_do_valid, bus.c0_do, bus.c1_do_valid); end
    @(negedge clk); bus.m_do = 8'd0; #1;
    nvec++; if ({bus.c0_do_valid, bus.c1_do_valid} !== 2'b00 || bus.c0_do !== 8'd7) begin nerr++; $display("FAIL b2b_end got %b/%0d want 00/7", {bus.c0_do_valid, bus.c1_do_valid}, bus.c0_do); end
  endtask

  task automatic test_write_no_return;
    drv_c1(1, 8'd8, 8'd80); bus.m_ready = 1;
    @(negedge clk); idle(); #1;
    nvec++; if ({bus.c0_do_valid, bus.c1_do_valid} !== 2'b00) begin nerr++; $display("FAIL wr_dovalid got %b want 00", {bus.c0_do_valid, bus.c1_do_valid}); end
    nvec++; if (bus.c1_wr_cnt !== 16'd5 || bus.c1_do !== 8'd6) begin nerr++; $display("FAIL wr_cnt got %0d/%0d want 5/6", bus.c1_wr_cnt, bus.c1_do); end
  endtask

  task automatic test_lock_drop;
    drv_c1(1, 8'd9, 8'd90); bus.m_ready = 0; #1;
    nvec++; if (bus.m_addr !== 8'd9) begin nerr++; $display("FAIL drop_lock got %0d want 9", bus.m_addr); end
    @(negedge clk); bus.c1_valid = 0; drv_c0(1, 8'd4, 8'd40); bus.m_ready = 1; #1;
    nvec++; if (bus.m_addr !== 8'd4 || {bus.c0_ready, bus.c1_ready} !== 2'b10) begin nerr++; $display("FAIL drop_grant got %0d/%b want 4/10", bus.m_addr, {bus.c0_ready, bus.c1_ready}); end
    @(negedge clk); idle(); #1;
    nvec++; if (bus.c0_wr_cnt !== 16'd6 || bus.c1_wr_cnt !== 16'd5) begin nerr++; $display("FAIL drop_cnt got %0d/%0d want 6/5", bus.c0_wr_cnt, bus.c1_wr_cnt); end
  endtask

  task automatic test_reset_mid_read;
    drv_c0(0, 8'd1, 8'd0); bus.m_ready = 1;
    @(negedge clk); idle(); rst = 1; bus.m_do = 8'd55; #1;
    nvec++; if ({bus.c0_do_valid, bus.c1_do_valid} !== 2'b00) begin nerr++; $display("FAIL rmr_inrst got %b want 00", {bus.c0_do_valid, bus.c1_do_valid}); end
    @(negedge clk); rst = 0; #1;
    nvec++; if ({bus.c0_do_valid, bus.c1_do_valid} !== 2'b00) begin nerr++; $display("FAIL rmr_after got %b want 00", {bus.c0_do_valid, bus.c1_do_valid}); end
    nvec++; if ({bus.c0_do, bus.c1_do} !== 16'd0 || {bus.c0_wr_cnt, bus.c1_wr_cnt} !== 32'd0) begin nerr++; $display("FAIL rmr_vals got %h/%h want 0/0", {bus.c0_do, bus.c1_do}, {bus.c0_wr_cnt, bus.c1_wr_cnt}); end
    drv_c0(0, 8'd1, 8'd0); drv_c1(0, 8'd2, 8'd0); bus.m_ready = 1; #1;
    nvec++; if ({bus.c0_ready, bus.c1_ready} !== 2'b10) begin nerr++; $display("FAIL rmr_first got %b want 10", {bus.c0_ready, bus.c1_ready}); end
    idle();
  endtask

  task automatic test_wrap;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    drv_c0(1, 8'd1, 8'd1); bus.m_ready = 1;
    repeat (65535) @(negedge clk);
    #1;
    nvec++; if (bus.c0_wr_cnt !== 16'hFFFF) begin nerr++; $display("FAIL wrap_pre got %h want ffff", bus.c0_wr_cnt); end
    @(negedge clk); idle(); #1;
    nvec++; if (bus.c0_wr_cnt !== 16'h0000 || bus.c1_wr_cnt !== 16'h0000) begin nerr++; $display("FAIL wrap got %h/%h want 0000/0000", bus.c0_wr_cnt, bus.c1_wr_cnt); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_stall_lock();
    test_read_routing();
    test_back_to_back();
    test_write_no_return();
    test_lock_drop();
    test_reset_mid_read();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
